// File: rtl/rw_read_arb.sv
// Round-robin read-address arbiter for N_PORTS requesters sharing one RW cache read port.
// Requests go through one registered stage tagged with the port index; responses are routed combinationally by tag.

// Per-port in-flight counter; the cap check uses the registered count only.
module rw_read_arb_cnt #(
  parameter int MAX_OUTSTANDING = 8
)(
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [7:0] o_cnt,
  output logic       o_open,
  output logic       o_underflow
);
  localparam logic [7:0] CAP = 8'(MAX_OUTSTANDING);

  logic [7:0] r_cnt;

  assign o_cnt       = r_cnt;
  assign o_open      = (r_cnt < CAP);
  assign o_underflow = i_dec & ~i_inc & (r_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!rstn)
      r_cnt <= 8'd0;
    else if (i_inc & ~i_dec)
      r_cnt <= r_cnt + 8'd1;
    else if (i_dec & ~i_inc & (r_cnt != 8'd0))
      r_cnt <= r_cnt - 8'd1;
  end
endmodule

module rw_read_arb #(
  parameter int N_PORTS         = 4,
  parameter int ID_W            = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int IDX_W           = 12,
  localparam int PW             = $clog2(N_PORTS)
)(
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [N_PORTS-1:0]              port_enable,
  input  logic [N_PORTS-1:0]              req_arvalid,
  output logic [N_PORTS-1:0]              req_arready,
  input  logic [N_PORTS-1:0][31:0]        req_araddr,
  input  logic [N_PORTS-1:0][ID_W-1:0]    req_arid,
  output logic                            mem_arvalid,
  input  logic                            mem_arready,
  output logic [31:0]                     mem_araddr,
  output logic [ID_W+PW-1:0]              mem_arid,
  input  logic                            mem_rvalid,
  output logic                            mem_rready,
  input  logic [ID_W+PW-1:0]              mem_rid,
  input  logic [511:0]                    mem_rdata,
  input  logic [IDX_W-1:0]                mem_rindex,
  output logic [N_PORTS-1:0]              resp_rvalid,
  input  logic [N_PORTS-1:0]              resp_rready,
  output logic [ID_W-1:0]                 resp_rid,
  output logic [511:0]                    resp_rdata,
  output logic [IDX_W-1:0]                resp_rindex,
  output logic [N_PORTS-1:0][7:0]         outstanding,
  output logic                            bad_rid
);
  logic                 r_vld;
  logic [31:0]          r_addr;
  logic [ID_W+PW-1:0]   r_id;
  logic [PW-1:0]        r_ptr;
  logic                 r_bad;

  logic [N_PORTS-1:0]   w_open;
  logic [N_PORTS-1:0]   w_elig;
  logic [N_PORTS-1:0]   w_underflow;
  logic                 w_load;
  logic                 w_found;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_q;
  logic                 w_q_ok;

  assign w_load      = ~r_vld | mem_arready;
  assign w_elig      = req_arvalid & port_enable & w_open;
  assign mem_arvalid = r_vld;
  assign mem_araddr  = r_addr;
  assign mem_arid    = r_id;
  assign bad_rid     = r_bad;

  // First eligible port at or after r_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(r_ptr) + i) % N_PORTS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_comb begin
    req_arready = '0;
    for (int p = 0; p < N_PORTS; p++)
      req_arready[p] = w_load & w_found & (w_win == PW'(p));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld  <= 1'b0;
      r_addr <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_vld <= w_found;
      if (w_found) begin
        r_addr <= req_araddr[w_win];
        r_id   <= {w_win, req_arid[w_win]};
        r_ptr  <= (w_win == PW'(N_PORTS-1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  // Return path: tag selects the port; unknown tags are drained and flagged.
  assign w_q         = mem_rid[ID_W+PW-1:ID_W];
  assign w_q_ok      = ({1'b0, w_q} < (PW+1)'(N_PORTS));
  assign resp_rid    = mem_rid[ID_W-1:0];
  assign resp_rdata  = mem_rdata;
  assign resp_rindex = mem_rindex;

  always_comb begin
    resp_rvalid = '0;
    mem_rready  = 1'b1;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_q == PW'(p)) begin
        resp_rvalid[p] = mem_rvalid;
        mem_rready     = resp_rready[p];
      end
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < N_PORTS; gp++) begin : g_port
      rw_read_arb_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .i_inc       (req_arvalid[gp] & req_arready[gp]),
        .i_dec       (resp_rvalid[gp] & resp_rready[gp]),
        .o_cnt       (outstanding[gp]),
        .o_open      (w_open[gp]),
        .o_underflow (w_underflow[gp])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn)
      r_bad <= 1'b0;
    else if ((mem_rvalid & ~w_q_ok) | (|w_underflow))
      r_bad <= 1'b1;
  end
endmodule

// File: tb/tb_rw_read_arb.sv
// Directed bench for rw_read_arb: a 4-port instance with a cap of 2 and a 3-port instance for out-of-range tags.
module tb_rw_read_arb;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // 4-port instance, MAX_OUTSTANDING=2
  logic [3:0]        a_en, a_arvalid, a_arready, a_rvalid, a_rready;
  logic [3:0][31:0]  a_araddr;
  logic [3:0][7:0]   a_arid, a_out;
  logic              a_marvalid, a_marready, a_mrvalid, a_mrready, a_bad;
  logic [31:0]       a_maraddr;
  logic [9:0]        a_marid, a_mrid;
  logic [511:0]      a_mrdata, a_rdata;
  logic [11:0]       a_mrindex, a_rindex;
  logic [7:0]        a_rid;

  // 3-port instance, default cap
  logic [2:0]        b_en, b_arvalid, b_arready, b_rvalid, b_rready;
  logic [2:0][31:0]  b_araddr;
  logic [2:0][7:0]   b_arid, b_out;
  logic              b_marvalid, b_marready, b_mrvalid, b_mrready, b_bad;
  logic [31:0]       b_maraddr;
  logic [9:0]        b_marid, b_mrid;
  logic [511:0]      b_mrdata, b_rdata;
  logic [11:0]       b_mrindex, b_rindex;
  logic [7:0]        b_rid;

  rw_read_arb #(.N_PORTS(4), .ID_W(8), .MAX_OUTSTANDING(2), .IDX_W(12)) u_a (
    .clk(clk), .rstn(rstn), .port_enable(a_en),
    .req_arvalid(a_arvalid), .req_arready(a_arready), .req_araddr(a_araddr), .req_arid(a_arid),
    .mem_arvalid(a_marvalid), .mem_arready(a_marready), .mem_araddr(a_maraddr), .mem_arid(a_marid),
    .mem_rvalid(a_mrvalid), .mem_rready(a_mrready), .mem_rid(a_mrid), .mem_rdata(a_mrdata),
    .mem_rindex(a_mrindex), .resp_rvalid(a_rvalid), .resp_rready(a_rready), .resp_rid(a_rid),
    .resp_rdata(a_rdata), .resp_rindex(a_rindex), .outstanding(a_out), .bad_rid(a_bad)
  );

  rw_read_arb #(.N_PORTS(3), .ID_W(8), .MAX_OUTSTANDING(8), .IDX_W(12)) u_b (
    .clk(clk), .rstn(rstn), .port_enable(b_en),
    .req_arvalid(b_arvalid), .req_arready(b_arready), .req_araddr(b_araddr), .req_arid(b_arid),
    .mem_arvalid(b_marvalid), .mem_arready(b_marready), .mem_araddr(b_maraddr), .mem_arid(b_marid),
    .mem_rvalid(b_mrvalid), .mem_rready(b_mrready), .mem_rid(b_mrid), .mem_rdata(b_mrdata),
    .mem_rindex(b_mrindex), .resp_rvalid(b_rvalid), .resp_rready(b_rready), .resp_rid(b_rid),
    .resp_rdata(b_rdata), .resp_rindex(b_rindex), .outstanding(b_out), .bad_rid(b_bad)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    a_en       = 4'hF;  a_arvalid = '0; a_araddr = '0; a_arid = '0;
    a_marready = 1'b1;  a_mrvalid = 1'b0; a_mrid = '0; a_mrdata = '0; a_mrindex = '0;
    a_rready   = 4'hF;
    b_en       = 3'h7;  b_arvalid = '0; b_araddr = '0; b_arid = '0;
    b_marready = 1'b1;  b_mrvalid = 1'b0; b_mrid = '0; b_mrdata = '0; b_mrindex = '0;
    b_rready   = 3'h7;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_arvalid", 64'(a_marvalid), 64'd0);
    chk("rst_out",     64'(a_out),      64'd0);
    chk("rst_bad",     64'(a_bad),      64'd0);

    // single port 2 request and its response
    a_arvalid = 4'b0100; a_araddr[2] = 32'h100; a_arid[2] = 8'd5;
    #1 chk("sp_ready", 64'(a_arready), 64'h4);
    tick();
    a_arvalid = '0;
    #1;
    chk("sp_arvalid", 64'(a_marvalid), 64'd1);
    chk("sp_araddr",  64'(a_maraddr),  64'h100);
    chk("sp_arid",    64'(a_marid),    64'h205);
    chk("sp_out1",    64'(a_out[2]),   64'd1);
    a_mrvalid = 1'b1; a_mrid = 10'h205; a_mrdata = {8{64'hDEAD_BEEF_0123_4567}}; a_mrindex = 12'h3A;
    #1;
    chk("sp_rvalid", 64'(a_rvalid),     64'h4);
    chk("sp_rid",    64'(a_rid),        64'd5);
    chk("sp_rready", 64'(a_mrready),    64'd1);
    chk("sp_rdata",  a_rdata[63:0],     64'hDEAD_BEEF_0123_4567);
    chk("sp_rindex", 64'(a_rindex),     64'h3A);
    tick();
    a_mrvalid = 1'b0;
    #1;
    chk("sp_out0",   64'(a_out[2]),   64'd0);
    chk("sp_drain",  64'(a_marvalid), 64'd0);

    // fairness: all ports request; cap of 2 ends it after two rounds
    do_reset();
    for (int p = 0; p < 4; p++) begin
      a_araddr[p] = 32'(p * 16);
      a_arid[p]   = 8'(p);
    end
    a_arvalid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      #1 chk("rr_ready", 64'(a_arready), 64'(oh));
      tick();
      chk("rr_arid",   64'(a_marid),   64'(((k % 4) << 8) | (k % 4)));
      chk("rr_araddr", 64'(a_maraddr), 64'((k % 4) * 16));
    end
    #1 chk("rr_capped", 64'(a_arready), 64'd0);
    chk("rr_outs", 64'(a_out), 64'h02020202);

    // cap: port 0 fills, port 1 still served, response reopens port 0 a cycle later
    do_reset();
    a_arvalid = 4'b0001;
    #1 chk("cap_g0", 64'(a_arready), 64'h1);
    tick();
    chk("cap_g1", 64'(a_arready), 64'h1);
    tick();
    a_arvalid = 4'b0011;
    #1;
    chk("cap_full", 64'(a_out[0]),  64'd2);
    chk("cap_p1",   64'(a_arready), 64'h2);
    tick();
    a_arvalid = 4'b0001; a_mrvalid = 1'b1; a_mrid = 10'h011;
    #1;
    chk("cap_stall", 64'(a_arready), 64'h0);
    chk("cap_resp",  64'(a_rvalid),  64'h1);
    tick();
    a_mrvalid = 1'b0;
    #1;
    chk("cap_dec",   64'(a_out[0]),  64'd1);
    chk("cap_reopn", 64'(a_arready), 64'h1);
    tick();

    // simultaneous request and response on port 1
    a_arvalid = 4'b0010; a_mrvalid = 1'b1; a_mrid = 10'h122;
    #1;
    chk("sim_ready", 64'(a_arready), 64'h2);
    chk("sim_resp",  64'(a_rvalid),  64'h2);
    tick();
    a_arvalid = '0; a_mrvalid = 1'b0;
    #1 chk("sim_out1", 64'(a_out[1]), 64'd1);

    // response for a port with nothing in flight: counter stays 0, error flagged
    a_mrvalid = 1'b1; a_mrid = 10'h300;
    #1 chk("uf_rvalid", 64'(a_rvalid), 64'h8);
    tick();
    a_mrvalid = 1'b0;
    #1;
    chk("uf_out3", 64'(a_out[3]), 64'd0);
    chk("uf_bad",  64'(a_bad),    64'd1);

    // backpressure: stage held while mem_arready low, drain and grant coincide
    do_reset();
    chk("bp_rstbad", 64'(a_bad), 64'd0);
    a_marready = 1'b0;
    a_araddr[0] = 32'hA0; a_arid[0] = 8'd7;
    a_araddr[1] = 32'hB0; a_arid[1] = 8'd9;
    a_arvalid = 4'b0011;
    #1 chk("bp_g0", 64'(a_arready), 64'h1);
    tick();
    a_arvalid = 4'b0010;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_noready", 64'(a_arready),  64'h0);
      chk("bp_vld",     64'(a_marvalid), 64'd1);
      chk("bp_addr",    64'(a_maraddr),  64'hA0);
      chk("bp_id",      64'(a_marid),    64'h007);
      tick();
    end
    a_marready = 1'b1;
    #1 chk("bp_release", 64'(a_arready), 64'h2);
    tick();
    a_arvalid = '0;
    chk("bp_addr2", 64'(a_maraddr), 64'hB0);
    chk("bp_id2",   64'(a_marid),   64'h109);

    // bad tag on the 3-port instance
    b_mrvalid = 1'b1; b_mrid = 10'h311; b_rready = 3'b000;
    #1;
    chk("bt_rready", 64'(b_mrready), 64'd1);
    chk("bt_rvalid", 64'(b_rvalid),  64'd0);
    chk("bt_pre",    64'(b_bad),     64'd0);
    tick();
    b_mrvalid = 1'b0;
    #1 chk("bt_bad", 64'(b_bad), 64'd1);
    tick();
    tick();
    chk("bt_sticky", 64'(b_bad), 64'd1);
    do_reset();
    chk("bt_clear", 64'(b_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
